// File: rtl/exception_ctrl.sv
// Precise-exception / iret sequencer: accept, drain store buffer, flush,
// redirect fetch; owns privilege bit and the rm_* exception registers.
`timescale 1ns/1ps
module exception_ctrl #(
   parameter int unsigned           WORD_SIZE    = 32,
   parameter int unsigned           CAUSE_WIDTH  = 2,
   parameter logic [WORD_SIZE-1:0]  HANDLER_PC   = 32'h2000,
   parameter int unsigned           FLUSH_CYCLES = 2,
   parameter int unsigned           CNT_WIDTH    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rob_exception,
   input  logic [WORD_SIZE-1:0]   rob_ex_pc,
   input  logic [WORD_SIZE-1:0]   rob_ex_vaddr,
   input  logic [CAUSE_WIDTH-1:0] rob_ex_cause,
   input  logic                   iret_commit,
   input  logic                   sb_empty,
   input  logic                   fetch_ready,
   output logic                   flush,
   output logic                   redirect_valid,
   output logic [WORD_SIZE-1:0]   redirect_pc,
   output logic                   supervisor,
   output logic [WORD_SIZE-1:0]   rm_epc,
   output logic [WORD_SIZE-1:0]   rm_vaddr,
   output logic [CAUSE_WIDTH-1:0] rm_cause,
   output logic                   busy,
   output logic [CNT_WIDTH-1:0]   exc_count
);

   localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DRAIN    = 2'd1,
      FLUSH    = 2'd2,
      REDIRECT = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [WORD_SIZE-1:0]   target_q, target_d;
   logic                   next_mode_q, next_mode_d;
   logic                   supervisor_q, supervisor_d;
   logic [WORD_SIZE-1:0]   epc_q, epc_d;
   logic [WORD_SIZE-1:0]   vaddr_q, vaddr_d;
   logic [CAUSE_WIDTH-1:0] cause_q, cause_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [FCW-1:0]         fcnt_q, fcnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         target_q     <= '0;
         next_mode_q  <= 1'b1;
         supervisor_q <= 1'b1;
         epc_q        <= '0;
         vaddr_q      <= '0;
         cause_q      <= '0;
         cnt_q        <= '0;
         fcnt_q       <= '0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         next_mode_q  <= next_mode_d;
         supervisor_q <= supervisor_d;
         epc_q        <= epc_d;
         vaddr_q      <= vaddr_d;
         cause_q      <= cause_d;
         cnt_q        <= cnt_d;
         fcnt_q       <= fcnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      next_mode_d  = next_mode_q;
      supervisor_d = supervisor_q;
      epc_d        = epc_q;
      vaddr_d      = vaddr_q;
      cause_d      = cause_q;
      cnt_d        = cnt_q;
      fcnt_d       = fcnt_q;
      case (state_q)
         IDLE: begin
            // Exception wins over a simultaneous iret; user-mode iret is dropped.
            if (rob_exception) begin
               epc_d       = rob_ex_pc;
               vaddr_d     = rob_ex_vaddr;
               cause_d     = rob_ex_cause;
               target_d    = HANDLER_PC;
               next_mode_d = 1'b1;
               if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
               state_d     = DRAIN;
            end else if (iret_commit && supervisor_q) begin
               target_d    = epc_q;
               next_mode_d = 1'b0;
               state_d     = DRAIN;
            end
         end
         DRAIN: begin
            if (sb_empty) begin
               fcnt_d  = FCW'(FLUSH_CYCLES - 1);
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (fcnt_q == '0) state_d = REDIRECT;
            else              fcnt_d  = fcnt_q - FCW'(1);
         end
         REDIRECT: begin
            // Mode switches only on the handshake edge.
            if (fetch_ready) begin
               supervisor_d = next_mode_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign flush          = (state_q == FLUSH);
   assign redirect_valid = (state_q == REDIRECT);
   assign busy           = (state_q != IDLE);
   assign redirect_pc    = target_q;
   assign supervisor     = supervisor_q;
   assign rm_epc         = epc_q;
   assign rm_vaddr       = vaddr_q;
   assign rm_cause       = cause_q;
   assign exc_count      = cnt_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: one task per scenario, inline checks,
// sampled on the falling edge while the DUT updates on the rising edge.
`timescale 1ns/1ps
module tb_exception_ctrl;

   logic        clk;
   logic        rst;
   logic        rob_exception;
   logic [31:0] rob_ex_pc;
   logic [31:0] rob_ex_vaddr;
   logic [1:0]  rob_ex_cause;
   logic        iret_commit;
   logic        sb_empty;
   logic        fetch_ready;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        supervisor;
   logic [31:0] rm_epc;
   logic [31:0] rm_vaddr;
   logic [1:0]  rm_cause;
   logic        busy;
   logic [15:0] exc_count;

   logic        s_flush, s_redirect_valid, s_supervisor, s_busy;
   logic [31:0] s_redirect_pc, s_rm_epc, s_rm_vaddr;
   logic [1:0]  s_rm_cause;
   logic [1:0]  s_exc_count;

   int tests = 0;
   int fails = 0;

   exception_ctrl dut (
      .clk(clk), .rst(rst), .rob_exception(rob_exception), .rob_ex_pc(rob_ex_pc),
      .rob_ex_vaddr(rob_ex_vaddr), .rob_ex_cause(rob_ex_cause), .iret_commit(iret_commit),
      .sb_empty(sb_empty), .fetch_ready(fetch_ready), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .supervisor(supervisor),
      .rm_epc(rm_epc), .rm_vaddr(rm_vaddr), .rm_cause(rm_cause), .busy(busy),
      .exc_count(exc_count)
   );

   exception_ctrl #(.CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst(rst), .rob_exception(rob_exception), .rob_ex_pc(rob_ex_pc),
      .rob_ex_vaddr(rob_ex_vaddr), .rob_ex_cause(rob_ex_cause), .iret_commit(iret_commit),
      .sb_empty(sb_empty), .fetch_ready(fetch_ready), .flush(s_flush),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .supervisor(s_supervisor),
      .rm_epc(s_rm_epc), .rm_vaddr(s_rm_vaddr), .rm_cause(s_rm_cause), .busy(s_busy),
      .exc_count(s_exc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raise a one-cycle exception request and walk it to IDLE (sb_empty=1, fetch_ready=1).
   task automatic run_exception(input logic [31:0] pc, input logic [31:0] va, input logic [1:0] c);
      sb_empty = 1'b1; fetch_ready = 1'b1;
      rob_exception = 1'b1; rob_ex_pc = pc; rob_ex_vaddr = va; rob_ex_cause = c;
      @(negedge clk); rob_exception = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %0b exp 0", busy); end
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_flush got %0b exp 0", flush); end
      tests++; if (redirect_valid !== 1'b0) begin fails++; $display("FAIL rst_rv got %0b exp 0", redirect_valid); end
      tests++; if (redirect_pc !== 32'h0) begin fails++; $display("FAIL rst_rpc got %h exp 0", redirect_pc); end
      tests++; if (supervisor !== 1'b1) begin fails++; $display("FAIL rst_sup got %0b exp 1", supervisor); end
      tests++; if (rm_epc !== 32'h0 || rm_vaddr !== 32'h0 || rm_cause !== 2'd0) begin
         fails++; $display("FAIL rst_rm got %h/%h/%0d exp 0/0/0", rm_epc, rm_vaddr, rm_cause); end
      tests++; if (exc_count !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", exc_count); end
      rst = 1'b0;
   endtask

   task automatic test_itlb();
      sb_empty = 1'b1; fetch_ready = 1'b1;
      rob_exception = 1'b1; rob_ex_pc = 32'h1004; rob_ex_vaddr = 32'h1004; rob_ex_cause = 2'd1;
      @(negedge clk); rob_exception = 1'b0;  // DRAIN
      tests++; if (busy !== 1'b1 || flush !== 1'b0) begin fails++; $display("FAIL itlb_drain busy/flush got %0b/%0b exp 1/0", busy, flush); end
      @(negedge clk);
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL itlb_flush1 got %0b exp 1", flush); end
      @(negedge clk);
      tests++; if (flush !== 1'b1 || redirect_valid !== 1'b0) begin fails++; $display("FAIL itlb_flush2 flush/rv got %0b/%0b exp 1/0", flush, redirect_valid); end
      @(negedge clk);
      tests++; if (redirect_valid !== 1'b1 || flush !== 1'b0) begin fails++; $display("FAIL itlb_redir rv/flush got %0b/%0b exp 1/0", redirect_valid, flush); end
      tests++; if (redirect_pc !== 32'h2000) begin fails++; $display("FAIL itlb_rpc got %h exp 00002000", redirect_pc); end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || supervisor !== 1'b1) begin fails++; $display("FAIL itlb_idle busy/sup got %0b/%0b exp 0/1", busy, supervisor); end
      tests++; if (rm_epc !== 32'h1004 || rm_vaddr !== 32'h1004 || rm_cause !== 2'd1) begin
         fails++; $display("FAIL itlb_rm got %h/%h/%0d exp 1004/1004/1", rm_epc, rm_vaddr, rm_cause); end
      tests++; if (exc_count !== 16'd1) begin fails++; $display("FAIL itlb_cnt got %0d exp 1", exc_count); end
   endtask

   task automatic test_iret_stall();
      sb_empty = 1'b1; fetch_ready = 1'b0; iret_commit = 1'b1;
      @(negedge clk); iret_commit = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL iret_busy got %0b exp 1", busy); end
      repeat (2) @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004 || supervisor !== 1'b1) begin
            fails++; $display("FAIL iret_hold%0d rv/pc/sup got %0b/%h/%0b exp 1/00001004/1", i, redirect_valid, redirect_pc, supervisor); end
         if (i == 4) fetch_ready = 1'b1;
      end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || supervisor !== 1'b0) begin fails++; $display("FAIL iret_done busy/sup got %0b/%0b exp 0/0", busy, supervisor); end
      tests++; if (exc_count !== 16'd1 || rm_epc !== 32'h1004) begin fails++; $display("FAIL iret_regs cnt/epc got %0d/%h exp 1/1004", exc_count, rm_epc); end
   endtask

   task automatic test_dtlb_user_drain();
      sb_empty = 1'b0; fetch_ready = 1'b1;
      rob_exception = 1'b1; rob_ex_pc = 32'h3000; rob_ex_vaddr = 32'hDEAD0000; rob_ex_cause = 2'd2;
      @(negedge clk); rob_exception = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         tests++; if (busy !== 1'b1 || flush !== 1'b0 || supervisor !== 1'b0) begin
            fails++; $display("FAIL dtlb_drain%0d busy/flush/sup got %0b/%0b/%0b exp 1/0/0", i, busy, flush, supervisor); end
         if (i == 5) sb_empty = 1'b1;
         @(negedge clk);
      end
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL dtlb_flush1 got %0b exp 1", flush); end
      @(negedge clk);
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL dtlb_flush2 got %0b exp 1", flush); end
      @(negedge clk);
      tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || supervisor !== 1'b0) begin
         fails++; $display("FAIL dtlb_redir rv/pc/sup got %0b/%h/%0b exp 1/00002000/0", redirect_valid, redirect_pc, supervisor); end
      tests++; if (rm_vaddr !== 32'hDEAD0000) begin fails++; $display("FAIL dtlb_vaddr got %h exp dead0000", rm_vaddr); end
      @(negedge clk);
      tests++; if (supervisor !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL dtlb_idle sup/busy got %0b/%0b exp 1/0", supervisor, busy); end
      tests++; if (rm_epc !== 32'h3000 || rm_cause !== 2'd2 || exc_count !== 16'd2) begin
         fails++; $display("FAIL dtlb_regs epc/cause/cnt got %h/%0d/%0d exp 3000/2/2", rm_epc, rm_cause, exc_count); end
   endtask

   task automatic test_priority_ignore();
      sb_empty = 1'b0; fetch_ready = 1'b1;
      rob_exception = 1'b1; iret_commit = 1'b1;
      rob_ex_pc = 32'h4000; rob_ex_vaddr = 32'h4444; rob_ex_cause = 2'd1;
      @(negedge clk);
      rob_ex_pc = 32'h5000; rob_ex_vaddr = 32'h5555; rob_ex_cause = 2'd3; iret_commit = 1'b0;
      tests++; if (busy !== 1'b1 || rm_epc !== 32'h4000 || exc_count !== 16'd3) begin
         fails++; $display("FAIL prio_accept busy/epc/cnt got %0b/%h/%0d exp 1/4000/3", busy, rm_epc, exc_count); end
      @(negedge clk); sb_empty = 1'b1;
      @(negedge clk); iret_commit = 1'b1;
      tests++; if (flush !== 1'b1 || rm_epc !== 32'h4000 || rm_cause !== 2'd1 || exc_count !== 16'd3) begin
         fails++; $display("FAIL prio_ignore flush/epc/cause/cnt got %0b/%h/%0d/%0d exp 1/4000/1/3", flush, rm_epc, rm_cause, exc_count); end
      @(negedge clk); rob_exception = 1'b0; iret_commit = 1'b0;
      @(negedge clk);
      tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000) begin
         fails++; $display("FAIL prio_target rv/pc got %0b/%h exp 1/00002000", redirect_valid, redirect_pc); end
      @(negedge clk);
      tests++; if (busy !== 1'b0 || supervisor !== 1'b1 || exc_count !== 16'd3 || rm_vaddr !== 32'h4444) begin
         fails++; $display("FAIL prio_end busy/sup/cnt/vaddr got %0b/%0b/%0d/%h exp 0/1/3/4444", busy, supervisor, exc_count, rm_vaddr); end
      iret_commit = 1'b1;
      @(negedge clk); iret_commit = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (supervisor !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL user_entry sup/busy got %0b/%0b exp 0/0", supervisor, busy); end
      iret_commit = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         @(negedge clk);
         tests++; if (busy !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL user_iret%0d busy/flush got %0b/%0b exp 0/0", i, busy, flush); end
      end
      iret_commit = 1'b0;
   endtask

   task automatic test_reset_mid_flush();
      sb_empty = 1'b1; fetch_ready = 1'b1;
      rob_exception = 1'b1; rob_ex_pc = 32'h6000; rob_ex_vaddr = 32'h6000; rob_ex_cause = 2'd1;
      @(negedge clk); rob_exception = 1'b0;
      @(negedge clk);
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL rstmid_pre flush got %0b exp 1", flush); end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      tests++; if (flush !== 1'b0 || busy !== 1'b0 || redirect_valid !== 1'b0) begin
         fails++; $display("FAIL rstmid_ctl flush/busy/rv got %0b/%0b/%0b exp 0/0/0", flush, busy, redirect_valid); end
      tests++; if (supervisor !== 1'b1 || exc_count !== 16'd0 || rm_epc !== 32'h0) begin
         fails++; $display("FAIL rstmid_regs sup/cnt/epc got %0b/%0d/%h exp 1/0/0", supervisor, exc_count, rm_epc); end
   endtask

   task automatic test_saturation();
      for (int n = 1; n <= 4; n++) begin
         run_exception(32'h7000 + 32'(n), 32'h8000, 2'd2);
         tests++; if (s_exc_count !== ((n < 3) ? 2'(n) : 2'd3)) begin
            fails++; $display("FAIL sat_cnt%0d got %0d exp %0d", n, s_exc_count, (n < 3) ? n : 3); end
      end
      tests++; if (exc_count !== 16'd4) begin fails++; $display("FAIL wide_cnt got %0d exp 4", exc_count); end
      tests++; if (rm_epc !== 32'h7004) begin fails++; $display("FAIL sat_epc got %h exp 7004", rm_epc); end
   endtask

   initial begin
      rst = 1'b1; rob_exception = 1'b0; rob_ex_pc = '0; rob_ex_vaddr = '0; rob_ex_cause = '0;
      iret_commit = 1'b0; sb_empty = 1'b1; fetch_ready = 1'b1;
      test_reset();
      test_itlb();
      test_iret_stall();
      test_dtlb_user_drain();
      test_priority_ignore();
      test_reset_mid_flush();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
